ex_div: RTL and testbench

- Multi-cycle integer divider in the execute stage of the 5-stage MIPS32 pipeline.
- It is the consumer of the operands carried by the decode/execute pipeline register.
- Execute asserts start_i with the two register operands and holds the pipeline stalled until ready_o.
- Result is packed {remainder, quotient} for writing HI/LO; one quotient bit is produced per cycle by restoring (trial-subtraction) division.

---
 rtl/ex_div_pkg.sv | 17 +
 rtl/ex_div.sv | 126 ++++++++++++
 tb/tb_ex_div.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ex_div_pkg.sv
// Shared constants for the execute-stage divider: FSM states, ready flag and
// start/stop request levels used by the execute and stall logic.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU; result packed {remainder, quotient}
// for HI/LO, one quotient bit per cycle, abortable by annul_i.
module ex_div
    import ex_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_e         state, state_n;
    logic [CW-1:0]      counter, counter_n;
    logic [WIDTH:0]     rem, rem_n;
    logic [WIDTH-1:0]   quo, quo_n;
    logic [WIDTH-1:0]   dvs, dvs_n;
    logic               neg_q, neg_q_n;
    logic               neg_r, neg_r_n;
    logic [2*WIDTH-1:0] result_n;
    logic               ready_n;

    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   diff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // quo starts as the dividend magnitude; its MSBs shift into the partial
    // remainder while quotient bits shift in at the bottom.
    assign shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign diff    = {1'b0, shifted} - {2'b00, dvs};
    assign q_fix   = neg_q ? -quo : quo;
    assign r_fix   = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

    always_comb begin
        state_n   = state;
        counter_n = counter;
        rem_n     = rem;
        quo_n     = quo;
        dvs_n     = dvs;
        neg_q_n   = neg_q;
        neg_r_n   = neg_r;
        result_n  = result_o;
        ready_n   = ready_o;
        unique case (state)
            DivFree: begin
                result_n = '0;
                ready_n  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    neg_q_n   = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                    neg_r_n   = signed_div_i && opdata1_i[WIDTH-1];
                    quo_n     = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
                    dvs_n     = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
                    rem_n     = '0;
                    counter_n = '0;
                    state_n   = (opdata2_i == '0) ? DivByZero : DivOn;
                end
            end
            DivByZero: begin
                result_n = '0;
                if (annul_i) begin
                    state_n = DivFree;
                    ready_n = DivResultNotReady;
                end else begin
                    state_n = DivEnd;
                    ready_n = DivResultReady;
                end
            end
            DivOn: begin
                if (annul_i) begin
                    state_n  = DivFree;
                    result_n = '0;
                    ready_n  = DivResultNotReady;
                end else if (counter == CW'(WIDTH)) begin
                    state_n  = DivEnd;
                    result_n = {r_fix, q_fix};
                    ready_n  = DivResultReady;
                end else begin
                    rem_n     = diff[WIDTH+1] ? shifted : diff[WIDTH:0];
                    quo_n     = {quo[WIDTH-2:0], ~diff[WIDTH+1]};
                    counter_n = counter + CW'(1);
                end
            end
            DivEnd: begin
                if (start_i == DivStop) begin
                    state_n  = DivFree;
                    result_n = '0;
                    ready_n  = DivResultNotReady;
                end
            end
            default: state_n = DivFree;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            counter  <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= DivResultNotReady;
        end else begin
            state    <= state_n;
            counter  <= counter_n;
            rem      <= rem_n;
            quo      <= quo_n;
            dvs      <= dvs_n;
            neg_q    <= neg_q_n;
            neg_r    <= neg_r_n;
            result_o <= result_n;
            ready_o  <= ready_n;
        end
    end

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: transaction-level reference model with a
// per-cycle compare, directed cases from the test plan plus random traffic.
module tb_ex_div;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           signed_div_i = 1'b0;
    logic [W-1:0]   opdata1_i = '0;
    logic [W-1:0]   opdata2_i = '0;
    logic           start_i = 1'b0;
    logic           annul_i = 1'b0;
    logic [2*W-1:0] result_o;
    logic           ready_o;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    ex_div #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    // Reference quotient/remainder from plain integer arithmetic.
    function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input logic s);
        longint sa, sb, q, r;
        if (b == '0) return '0;
        if (!s) return {a % b, a / b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        r  = sa % sb;
        return {r[W-1:0], q[W-1:0]};
    endfunction

    // Model: idle / busy for a fixed latency / done holding the result.
    int             m_phase = 0;
    int             m_left = 0;
    logic [2*W-1:0] m_pend = '0;
    logic           m_ready = 1'b0;
    logic [2*W-1:0] m_result = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= 0;
            m_ready  <= 1'b0;
            m_result <= '0;
        end else begin
            case (m_phase)
                0: if (start_i && !annul_i) begin
                    m_pend  <= ref_div(opdata1_i, opdata2_i, signed_div_i);
                    m_left  <= (opdata2_i == '0) ? 1 : W + 1;
                    m_phase <= 1;
                end
                1: if (annul_i) m_phase <= 0;
                   else if (m_left == 1) begin
                       m_phase  <= 2;
                       m_ready  <= 1'b1;
                       m_result <= m_pend;
                   end else m_left <= m_left - 1;
                default: if (!start_i) begin
                    m_phase  <= 0;
                    m_ready  <= 1'b0;
                    m_result <= '0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (ready_o !== m_ready || result_o !== m_result) begin
                errors++;
                $display("FAIL cycle_compare t=%0t ready=%b result=%h required ready=%b result=%h",
                         $time, ready_o, result_o, m_ready, m_result);
            end
        end
    end

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One division: accept, optional annul at edge annul_at, hold result for hold cycles.
    task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input int annul_at, input int hold,
                          input bit use_lit, input logic [2*W-1:0] lit, input bit annul_in_end);
        int lat;
        bit done;
        lat = (b == '0) ? 1 : W + 1;
        done = 1'b0;
        opdata1_i = a; opdata2_i = b; signed_div_i = s;
        start_i = 1'b1; annul_i = 1'b0;
        tick();
        opdata1_i = $urandom; opdata2_i = $urandom; signed_div_i = $urandom_range(0, 1);
        for (int e = 1; e <= 100 && !done; e++) begin
            if (e == annul_at) annul_i = 1'b1;
            tick();
            if (e == annul_at) begin
                annul_i = 1'b0; start_i = 1'b0;
                check({name, "_annul_ready"}, {63'd0, ready_o}, '0);
                tick();
                check({name, "_annul_idle"}, {63'd0, ready_o}, '0);
                return;
            end
            if (ready_o) begin
                check({name, "_latency"}, 64'(e), 64'(lat));
                if (use_lit) check({name, "_result"}, result_o, lit);
                done = 1'b1;
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout ready=%b required=1 within 100 edges", name, ready_o);
            start_i = 1'b0;
            tick();
            return;
        end
        for (int h = 0; h < hold; h++) begin
            annul_i = annul_in_end;
            tick();
            if (use_lit) check({name, "_hold"}, result_o, lit);
        end
        annul_i = 1'b0;
        start_i = 1'b0;
        tick();
        check({name, "_clear"}, {ready_o, result_o[2*W-2:0]} | {63'd0, result_o[2*W-1]}, '0);
    endtask

    initial begin
        // pin the reference model with hand-computed values
        check("ref_u100_7", ref_div(32'd100, 32'd7, 1'b0), {32'd2, 32'd14});
        check("ref_s-7_2", ref_div(32'hFFFFFFF9, 32'd2, 1'b1), {32'hFFFFFFFF, 32'hFFFFFFFD});
        check("ref_s7_-2", ref_div(32'd7, 32'hFFFFFFFE, 1'b1), {32'h00000001, 32'hFFFFFFFD});
        check("ref_s_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b1), {32'h0, 32'h80000000});
        check("ref_u_ovf", ref_div(32'h80000000, 32'hFFFFFFFF, 1'b0), {32'h80000000, 32'h0});

        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        tick();
        check("reset_state", {ready_o, result_o[2*W-2:0]}, '0);
        rst = 1'b0;
        tick();

        do_div("u100_7", 32'd100, 32'd7, 1'b0, 0, 4, 1'b1, {32'd2, 32'd14}, 1'b0);
        do_div("s-7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 0, 1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
        do_div("s7_-2", 32'd7, 32'hFFFFFFFE, 1'b1, 0, 1, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 1'b1);
        do_div("by_zero", 32'd5, 32'd0, 1'b0, 0, 2, 1'b1, '0, 1'b0);
        do_div("by_zero_annul", 32'd5, 32'd0, 1'b0, 1, 0, 1'b0, '0, 1'b0);
        do_div("annul_1000_3", 32'd1000, 32'd3, 1'b0, 10, 0, 1'b0, '0, 1'b0);
        do_div("u_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 0, 1, 1'b1, {32'h0, 32'hFFFFFFFF}, 1'b0);
        do_div("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, 0, 1, 1'b1, {32'h0, 32'h80000000}, 1'b0);
        do_div("u_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b0, 0, 1, 1'b1, {32'h80000000, 32'h0}, 1'b0);

        // reset in the middle of a division
        opdata1_i = 32'd1000; opdata2_i = 32'd3; signed_div_i = 1'b0; start_i = 1'b1;
        for (int e = 0; e < 15; e++) tick();
        rst = 1'b1;
        tick();
        check("mid_reset", {ready_o, result_o[2*W-2:0]}, '0);
        rst = 1'b0; start_i = 1'b0;
        tick();
        do_div("after_reset", 32'd1000, 32'd3, 1'b0, 0, 0, 1'b1, {32'd1, 32'd333}, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            logic s;
            int an;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = '0;
                1: b = '1;
                2: b = W'($urandom_range(1, 20));
                3: a = 32'h80000000;
                default: ;
            endcase
            an = ($urandom_range(0, 4) == 0) ? $urandom_range(1, (b == '0) ? 1 : W + 1) : 0;
            do_div("random", a, b, s, an, $urandom_range(0, 3), 1'b1, ref_div(a, b, s),
                   1'($urandom_range(0, 1)));
        end

        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
